// File: rtl/bios_ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bios_ram_arb_pkg
// Description : Shared types and constants for the BIOS RAM arbiter.
// Revision    : 1.0
// ============================================================================
package bios_ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD     = 2'd1,
        RDDONE = 2'd2
    } arb_state_t;

    localparam logic [7:0] BIOS_INDEX_DEFAULT = 8'h00;

    // True when the host byte address fits inside a RAM of 2**aw bytes.
    function automatic logic addr_in_range(input logic [24:0] addr, input int unsigned aw);
        return (addr >> aw) == 25'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bios_ram_arb_wr_buf.sv
`default_nettype none
// ============================================================================
// Module      : bios_wr_buf
// Description : One-entry host write buffer with out-of-range detection.
// Revision    : 1.0
// ============================================================================
module bios_wr_buf
    import bios_ram_arb_pkg::*;
#(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [24:0]   addr,
    input  logic [7:0]    din,
    input  logic          drain,
    output logic          full,
    output logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_data,
    output logic          ovf,
    output logic          captured
);

    logic in_range;
    logic take;

    // A strobe arriving while full is a host protocol error and is dropped.
    assign in_range = addr_in_range(addr, AW);
    assign take     = wr && !full;
    assign captured = take && in_range;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full     <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
            ovf      <= 1'b0;
        end else begin
            if (drain) begin
                full <= 1'b0;
            end
            if (captured) begin
                full     <= 1'b1;
                buf_addr <= addr[AW-1:0];
                buf_data <= din;
            end
            if (take && !in_range) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bios_ram_arb.sv
`default_nettype none
// ============================================================================
// Module      : bios_ram_arb
// Description : Arbitrates BIOS RAM between host download writes and CPU reads.
//               Optional BIOS_ARB_CHECKSUM_EN builds the running byte checksum.
// Revision    : 1.0
// ============================================================================
module bios_ram_arb
    import bios_ram_arb_pkg::*;
#(
    parameter int         AW         = 13,
    parameter int         DW         = 8,
    parameter logic [7:0] BIOS_INDEX = BIOS_INDEX_DEFAULT
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic [7:0]    ioctl_index,
    output logic          ioctl_wait,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_data,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          cpu_hold,
    output logic          loaded,
    output logic          ovf,
    output logic [7:0]    checksum
);

    arb_state_t    state;
    arb_state_t    state_nx;
    logic          match;
    logic          rise;
    logic          fall;
    logic          full;
    logic          drain;
    logic          captured;
    logic          any_byte;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_data;

    assign match      = ioctl_download && (ioctl_index == BIOS_INDEX);
    assign rise       = match && !cpu_hold;
    assign fall       = !match && cpu_hold;
    assign ioctl_wait = full;

    bios_wr_buf #(
        .AW (AW)
    ) u_wr_buf (
        .clk      (clk_sys),
        .reset    (reset),
        .wr       (ioctl_wr && match),
        .addr     (ioctl_addr),
        .din      (ioctl_dout),
        .drain    (drain),
        .full     (full),
        .buf_addr (buf_addr),
        .buf_data (buf_data),
        .ovf      (ovf),
        .captured (captured)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
        end else begin
            state    <= state_nx;
            cpu_hold <= match;
        end
    end

    always_comb begin
        state_nx = state;
        mem_ce   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        drain    = 1'b0;
        cpu_ack  = 1'b0;
        case (state)
            IDLE: begin
                if (full) begin
                    mem_ce   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = buf_addr;
                    mem_din  = DW'(buf_data);
                    drain    = 1'b1;
                end else if (cpu_req && !cpu_hold) begin
                    mem_ce   = 1'b1;
                    mem_addr = cpu_addr;
                    state_nx = RD;
                end
            end
            RD:      state_nx = RDDONE;
            // A download that started mid-read suppresses the ack; the CPU
            // keeps cpu_req high and is re-served once the window closes.
            RDDONE: begin
                state_nx = IDLE;
                cpu_ack  = !cpu_hold;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Only latch data for a read that will actually be acknowledged.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cpu_data <= '0;
        end else if (state == RD && !match) begin
            cpu_data <= mem_dout;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            loaded   <= 1'b0;
            any_byte <= 1'b0;
        end else if (rise) begin
            loaded   <= 1'b0;
            any_byte <= captured;
        end else begin
            if (captured) begin
                any_byte <= 1'b1;
            end
            if (fall && any_byte) begin
                loaded <= 1'b1;
            end
        end
    end

`ifdef BIOS_ARB_CHECKSUM_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            checksum <= 8'h00;
        end else if (rise) begin
            checksum <= 8'h00;
        end else if (drain) begin
            checksum <= checksum + buf_data;
        end
    end
`else
    assign checksum = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bios_ram_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_bios_ram_arb
// Description : Self-checking bench for bios_ram_arb with a RAM model.
// Revision    : 1.0
// ============================================================================
module tb_bios_ram_arb;

    localparam int         AW   = 13;
    localparam int         DW   = 8;
    localparam logic [7:0] BIDX = 8'h00;
`ifdef BIOS_ARB_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [24:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_dout = '0;
    logic [7:0]    ioctl_index = '0;
    logic          ioctl_wait;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_data;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          cpu_hold;
    logic          loaded;
    logic          ovf;
    logic [7:0]    checksum;

    int n_total = 0;
    int n_pass  = 0;

    bios_ram_arb dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .cpu_req        (cpu_req),
        .cpu_addr       (cpu_addr),
        .cpu_ack        (cpu_ack),
        .cpu_data       (cpu_data),
        .mem_ce         (mem_ce),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .cpu_hold       (cpu_hold),
        .loaded         (loaded),
        .ovf            (ovf),
        .checksum       (checksum)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] init_val(input int i);
        return (i == 32'h1FF0) ? 8'hEA : (i[7:0] ^ 8'hA5);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Synchronous RAM with one-cycle read latency.
    logic [7:0] ram [0:8191];
    logic       preload = 1'b1;
    always @(posedge clk_sys) begin
        if (preload) begin
            for (int i = 0; i < 8192; i++) ram[i] <= init_val(i);
            mem_dout <= '0;
        end else if (mem_ce) begin
            if (mem_we) ram[mem_addr] <= mem_din;
            else        mem_dout <= ram[mem_addr];
        end
    end

    // Behavioural model: pending host bytes, read age since acceptance, window rules.
    logic [7:0]  exp_ram [0:8191];
    logic [20:0] pend [$];
    int          m_age = 0;
    logic        m_hold = 1'b0, m_ovf = 1'b0, m_loaded = 1'b0, m_any = 1'b0;
    logic [7:0]  m_sum = 8'h00, m_data = 8'h00, m_rdata = 8'h00;
    logic        mt, rs, fl, busy, e_we, e_acc, e_ack, full_now, acc_wr, acc_in;

    always @(negedge clk_sys) begin
        if (preload) for (int i = 0; i < 8192; i++) exp_ram[i] = init_val(i);
        if (reset) begin
            check("rst_wait", ioctl_wait, 0);
            check("rst_ack", cpu_ack, 0);
            check("rst_data", cpu_data, 0);
            check("rst_ce", mem_ce, 0);
            check("rst_we", mem_we, 0);
            check("rst_addr", mem_addr, 0);
            check("rst_din", mem_din, 0);
            check("rst_hold", cpu_hold, 0);
            check("rst_loaded", loaded, 0);
            check("rst_ovf", ovf, 0);
            check("rst_cksum", checksum, 0);
            pend.delete();
            m_age = 0; m_hold = 0; m_ovf = 0; m_loaded = 0; m_any = 0;
            m_sum = 0; m_data = 0;
        end else begin
            mt       = ioctl_download && (ioctl_index == BIDX);
            rs       = mt && !m_hold;
            fl       = !mt && m_hold;
            busy     = (m_age != 0);
            full_now = (pend.size() > 0);
            e_we     = full_now && !busy;
            e_acc    = !e_we && !busy && cpu_req && !m_hold;
            e_ack    = (m_age == 2) && !m_hold;
            check("hold", cpu_hold, m_hold);
            check("wait", ioctl_wait, full_now);
            check("mem_ce", mem_ce, e_we || e_acc);
            check("mem_we", mem_we, e_we);
            if (e_we) begin
                check("wr_addr", mem_addr, pend[0][20:8]);
                check("wr_data", mem_din, pend[0][7:0]);
            end
            if (e_acc) check("rd_addr", mem_addr, cpu_addr);
            check("ack", cpu_ack, e_ack);
            check("cpu_data", cpu_data, e_ack ? m_rdata : m_data);
            check("ovf", ovf, m_ovf);
            check("loaded", loaded, m_loaded);
            check("checksum", checksum, CK_EN ? m_sum : 8'h00);

            acc_wr = ioctl_wr && mt && !full_now;
            acc_in = acc_wr && (ioctl_addr < 25'd8192);
            if (rs) m_sum = 8'h00;
            else if (e_we) m_sum = m_sum + pend[0][7:0];
            if (e_we) begin
                exp_ram[pend[0][20:8]] = pend[0][7:0];
                void'(pend.pop_front());
            end
            if (acc_in) pend.push_back({ioctl_addr[12:0], ioctl_dout});
            if (acc_wr && !acc_in) m_ovf = 1'b1;
            if (rs) begin
                m_loaded = 1'b0;
                m_any    = acc_in;
            end else begin
                if (acc_in) m_any = 1'b1;
                if (fl && m_any) m_loaded = 1'b1;
            end
            if (e_ack) m_data = m_rdata;
            if (e_acc) begin
                m_age   = 1;
                m_rdata = exp_ram[cpu_addr];
            end else if (m_age == 1) m_age = 2;
            else if (m_age == 2) m_age = 0;
            m_hold = mt;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic host_wr(input logic [24:0] a, input logic [7:0] d);
        int n = 0;
        while (ioctl_wait && n < 10) begin
            tick();
            n++;
        end
        if (ioctl_wait) check("host_wait_bound", ioctl_wait, 0);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!cpu_ack && n < 20);
        if (!cpu_ack) check("ack_timeout", cpu_ack, 1);
    endtask

    int n;
    int wcnt;
    logic ack_seen;

    initial begin
        repeat (3) tick();
        preload = 1'b0;
        reset   = 1'b0;
        tick();
        check("post_rst_wait", ioctl_wait, 0);

        // Read of preloaded byte: ack exactly two cycles after acceptance.
        cpu_addr = 13'h1FF0;
        cpu_req  = 1'b1;
        wait_ack(n);
        check("rd_latency", n, 2);
        check("rd_data_ea", cpu_data, 8'hEA);
        cpu_req = 1'b0;
        tick();

        // BIOS download of four bytes.
        ioctl_index    = 8'h00;
        ioctl_download = 1'b1;
        tick();
        check("dl_hold", cpu_hold, 1);
        host_wr(25'd0, 8'h01);
        host_wr(25'd1, 8'h02);
        host_wr(25'd2, 8'h03);
        host_wr(25'd3, 8'hFF);
        ioctl_download = 1'b0;
        repeat (3) tick();
        check("dl_loaded", loaded, 1);
        check("dl_cksum", checksum, CK_EN ? 8'h05 : 8'h00);
        check("ram0", ram[0], 8'h01);
        check("ram1", ram[1], 8'h02);
        check("ram2", ram[2], 8'h03);
        check("ram3", ram[3], 8'hFF);

        // Host strobe while the read is in RD.
        cpu_addr = 13'd3;
        cpu_req  = 1'b1;
        tick();
        ioctl_download = 1'b1;
        ioctl_addr     = 25'd10;
        ioctl_dout     = 8'h77;
        ioctl_wr       = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        wcnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (ioctl_wait) wcnt++;
            tick();
        end
        check("wait_in_rd", wcnt, 2);
        ioctl_download = 1'b0;
        wait_ack(n);
        check("reread_data", cpu_data, 8'hFF);
        cpu_req = 1'b0;
        tick();
        check("ram10", ram[10], 8'h77);
        check("win2_loaded", loaded, 1);
        check("win2_cksum", checksum, CK_EN ? 8'h77 : 8'h00);

        // Out-of-range byte only.
        ioctl_download = 1'b1;
        tick();
        host_wr(25'h2000, 8'h55);
        tick();
        ioctl_download = 1'b0;
        repeat (2) tick();
        check("ovf_set", ovf, 1);
        check("ovf_loaded", loaded, 0);
        check("ovf_cksum", checksum, 8'h00);
        check("ovf_ram0", ram[0], 8'h01);

        // Non-BIOS index: no writes, CPU not held.
        ioctl_index    = 8'h01;
        ioctl_download = 1'b1;
        repeat (2) tick();
        check("idx1_hold", cpu_hold, 0);
        host_wr(25'd5, 8'h99);
        cpu_addr = 13'd5;
        cpu_req  = 1'b1;
        wait_ack(n);
        check("idx1_latency", n, 2);
        check("idx1_data", cpu_data, 8'hA0);
        cpu_req        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        tick();
        check("idx1_ram5", ram[5], 8'hA0);
        check("ovf_sticky", ovf, 1);

        // Reset in RD aborts the read.
        cpu_addr = 13'h1FF0;
        cpu_req  = 1'b1;
        tick();
        reset   = 1'b1;
        cpu_req = 1'b0;
        #1;
        check("abort_data", cpu_data, 0);
        check("abort_ovf", ovf, 0);
        tick();
        reset    = 1'b0;
        ack_seen = 1'b0;
        repeat (5) begin
            tick();
            if (cpu_ack) ack_seen = 1'b1;
        end
        check("abort_no_ack", ack_seen, 0);

        // Reset with a buffered byte loses it.
        ioctl_download = 1'b1;
        tick();
        ioctl_addr = 25'd20;
        ioctl_dout = 8'h42;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr       = 1'b0;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        #1;
        check("lost_wait", ioctl_wait, 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("lost_ram20", ram[20], 8'hB1);
        check("lost_loaded", loaded, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
